// File: rtl/rps_opponent.sv
// Rock-paper-scissors opponent: an 8-bit LFSR picks the computer's move, and a
// four-state FSM judges each round and keeps match scores up to MATCH_LEN wins.
module rps_opponent #(
    parameter logic [7:0] SEED      = 8'hA5,
    parameter int         MATCH_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       player_valid,
    input  logic [1:0] player,
    input  logic       new_match,
    output logic       player_ready,
    output logic [1:0] computer,
    output logic       result_valid,
    output logic [1:0] result,
    output logic [3:0] player_score,
    output logic [3:0] computer_score,
    output logic       match_over
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [3:0] MATCH_MAX = 4'(MATCH_LEN);

    if (MATCH_LEN < 1 || MATCH_LEN > 15) begin : g_bad_match_len
        $error("rps_opponent: MATCH_LEN must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        JUDGE,
        RESULT,
        OVER
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] lfsr;
    logic [1:0] player_hold;
    logic [1:0] move_sel;
    logic [1:0] outcome;
    logic       accept;

    function automatic logic [1:0] select_move(input logic [7:0] value);
        if (value[1:0] != 2'b11) begin
            return value[1:0];
        end else if (value[3:2] != 2'b11) begin
            return value[3:2];
        end
        return 2'b00;
    endfunction

    function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
        if (p == 2'b11) begin
            return 2'b11;
        end
        if (p == c) begin
            return 2'b00;
        end
        case ({p, c})
            4'b00_10, 4'b01_00, 4'b10_01: return 2'b01;
            default:                      return 2'b10;
        endcase
    endfunction

    assign move_sel = select_move(lfsr);
    assign outcome  = judge(player_hold, computer);
    assign accept   = (state == IDLE) && player_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (player_valid) state_next = JUDGE;
            JUDGE:   state_next = RESULT;
            RESULT:  begin
                if (player_score == MATCH_MAX || computer_score == MATCH_MAX) begin
                    state_next = OVER;
                end else begin
                    state_next = IDLE;
                end
            end
            OVER:    if (new_match) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The player's move is only consumed in JUDGE, which reset never leaves us in.
    always_ff @(posedge clk) begin
        if (accept) begin
            player_hold <= player;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            computer       <= 2'b00;
            result         <= 2'b00;
            player_score   <= 4'd0;
            computer_score <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_match) begin
                        result         <= 2'b00;
                        player_score   <= 4'd0;
                        computer_score <= 4'd0;
                    end
                    if (player_valid) begin
                        computer <= move_sel;
                    end
                end
                JUDGE: begin
                    result <= outcome;
                    if (outcome == 2'b01 && player_score != MATCH_MAX) begin
                        player_score <= player_score + 4'd1;
                    end
                    if (outcome == 2'b10 && computer_score != MATCH_MAX) begin
                        computer_score <= computer_score + 4'd1;
                    end
                end
                OVER: begin
                    if (new_match) begin
                        result         <= 2'b00;
                        player_score   <= 4'd0;
                        computer_score <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign player_ready = (state == IDLE);
    assign result_valid = (state == RESULT);
    assign match_over   = (state == OVER);

endmodule

// File: tb/tb_rps_opponent.sv
// Bench for rps_opponent: two instances (MATCH_LEN 3 and 1) share directed stimulus
// and are compared every cycle against a round-level model, plus literal spot checks.
module tb_rps_opponent;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       player_valid = 1'b0;
    logic [1:0] player = 2'b00;
    logic       new_match = 1'b0;

    logic       ready [2];
    logic [1:0] comp  [2];
    logic       rv    [2];
    logic [1:0] res   [2];
    logic [3:0] ps    [2];
    logic [3:0] cs    [2];
    logic       over  [2];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    rps_opponent #(.SEED(8'hA5), .MATCH_LEN(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .player_valid(player_valid), .player(player),
        .new_match(new_match), .player_ready(ready[0]), .computer(comp[0]),
        .result_valid(rv[0]), .result(res[0]), .player_score(ps[0]),
        .computer_score(cs[0]), .match_over(over[0])
    );

    rps_opponent #(.SEED(8'hA5), .MATCH_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .player_valid(player_valid), .player(player),
        .new_match(new_match), .player_ready(ready[1]), .computer(comp[1]),
        .result_valid(rv[1]), .result(res[1]), .player_score(ps[1]),
        .computer_score(cs[1]), .match_over(over[1])
    );

    task automatic check(input string name, input int inst, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- round-level model ----------------
    int         m_ml   [2] = '{3, 1};
    logic [7:0] m_lfsr [2];
    int         m_busy [2];   // 0 = waiting for a move, 1 = move taken, 2 = result shown
    bit         m_over [2];
    logic [1:0] m_comp [2];
    logic [1:0] m_res  [2];
    logic [1:0] m_pmove[2];
    int         m_ps   [2];
    int         m_cs   [2];

    function automatic logic [1:0] pick(input logic [7:0] l);
        if (l[1:0] != 2'b11) return l[1:0];
        if (l[3:2] != 2'b11) return l[3:2];
        return 2'b00;
    endfunction

    function automatic logic [1:0] round_outcome(input logic [1:0] p, input logic [1:0] c);
        int loser;
        if (p == 2'b11) return 2'b11;
        if (p == c) return 2'b00;
        loser = (int'(p) + 2) % 3;   // the move p beats
        return (int'(c) == loser) ? 2'b01 : 2'b10;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] sel;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_lfsr[i] = 8'hA5; m_busy[i] = 0; m_over[i] = 0;
                m_comp[i] = 2'b00; m_res[i] = 2'b00; m_pmove[i] = 2'b00;
                m_ps[i] = 0; m_cs[i] = 0;
            end else begin
                sel = pick(m_lfsr[i]);
                if (m_over[i]) begin
                    if (new_match) begin
                        m_over[i] = 0; m_ps[i] = 0; m_cs[i] = 0; m_res[i] = 2'b00;
                    end
                end else if (m_busy[i] == 0) begin
                    if (new_match) begin
                        m_ps[i] = 0; m_cs[i] = 0; m_res[i] = 2'b00;
                    end
                    if (player_valid) begin
                        m_pmove[i] = player; m_comp[i] = sel; m_busy[i] = 1;
                    end
                end else if (m_busy[i] == 1) begin
                    m_res[i] = round_outcome(m_pmove[i], m_comp[i]);
                    if (m_res[i] == 2'b01 && m_ps[i] < m_ml[i]) m_ps[i]++;
                    if (m_res[i] == 2'b10 && m_cs[i] < m_ml[i]) m_cs[i]++;
                    m_busy[i] = 2;
                end else begin
                    m_busy[i] = 0;
                    if (m_ps[i] == m_ml[i] || m_cs[i] == m_ml[i]) m_over[i] = 1;
                end
                m_lfsr[i] = {m_lfsr[i][6:0],
                             m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit rv_prev[2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("player_ready", i, ready[i], (m_busy[i] == 0 && !m_over[i]) ? 1 : 0);
            check("computer", i, comp[i], m_comp[i]);
            check("result_valid", i, rv[i], (m_busy[i] == 2) ? 1 : 0);
            check("result", i, res[i], m_res[i]);
            check("player_score", i, ps[i], m_ps[i]);
            check("computer_score", i, cs[i], m_cs[i]);
            check("match_over", i, over[i], m_over[i] ? 1 : 0);
            check("computer_legal", i, (comp[i] != 2'b11) ? 1 : 0, 1);
            if (rv_prev[i]) check("result_valid_twice", i, rv[i], 0);
            rv_prev[i] = rv[i];
        end
        check("lfsr", 0, dut0.lfsr, m_lfsr[0]);
        check("lfsr", 1, dut1.lfsr, m_lfsr[1]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset state
        tick(); tick(); tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", i, ready[i], 1);
            check("rst_computer", i, comp[i], 0);
            check("rst_result_valid", i, rv[i], 0);
            check("rst_match_over", i, over[i], 0);
        end

        // Rock against seed A5 -> computer Paper, computer wins
        rst_n = 1'b1; player_valid = 1'b1; player = 2'b00;
        tick();
        player_valid = 1'b0;
        check("rock_computer", 0, comp[0], 1);
        tick();
        check("rock_rv", 0, rv[0], 1);
        check("rock_result", 0, res[0], 2);
        check("rock_cscore", 0, cs[0], 1);
        check("rock_pscore", 0, ps[0], 0);
        tick();
        check("rock_rv_clear", 0, rv[0], 0);
        check("rock_ready", 0, ready[0], 1);
        check("len1_over", 1, over[1], 1);
        check("len1_ready", 1, ready[1], 0);

        // Invalid move: result 11, scores untouched
        player_valid = 1'b1; player = 2'b11;
        tick();
        player_valid = 1'b0;
        tick();
        check("invalid_result", 0, res[0], 3);
        check("invalid_cscore", 0, cs[0], 1);
        check("invalid_pscore", 0, ps[0], 0);
        tick();
        check("invalid_ready", 0, ready[0], 1);

        // Moves ignored while the MATCH_LEN=1 instance is over
        player_valid = 1'b1; player = 2'b00;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("over_ignore_ready", 1, ready[1], 0);
            check("over_ignore_cscore", 1, cs[1], 1);
        end
        player_valid = 1'b0;
        tick(); tick(); tick();
        new_match = 1'b1;
        tick();
        new_match = 1'b0;
        check("newmatch_cscore", 1, cs[1], 0);
        check("newmatch_pscore", 1, ps[1], 0);
        check("newmatch_ready", 1, ready[1], 1);
        check("newmatch_over", 1, over[1], 0);

        // Paper against seed A5 -> draw
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1; player_valid = 1'b1; player = 2'b01;
        tick();
        player_valid = 1'b0;
        check("paper_computer", 0, comp[0], 1);
        check("paper_computer", 1, comp[1], 1);
        tick();
        check("paper_result", 0, res[0], 0);
        check("paper_rv", 1, rv[1], 1);
        check("paper_cscore", 0, cs[0], 0);
        check("paper_pscore", 0, ps[0], 0);
        tick();

        // Reset asserted in JUDGE discards the round
        player_valid = 1'b1; player = 2'b10;
        tick();
        player_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("midrst_ready", i, ready[i], 1);
            check("midrst_computer", i, comp[i], 0);
            check("midrst_rv", i, rv[i], 0);
        end
        check("midrst_lfsr", 0, dut0.lfsr, 8'hA5);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("postrst_rv", 0, rv[0], 0);
            check("postrst_rv", 1, rv[1], 0);
        end

        // Same-edge new_match and accept in IDLE, then a long continuous-valid run
        player_valid = 1'b1; player = 2'b10;
        tick();
        player_valid = 1'b0;
        tick(); tick();
        new_match = 1'b1; player_valid = 1'b1; player = 2'b00;
        tick();
        new_match = 1'b0;
        for (int c = 0; c < 300; c++) begin
            player = 2'($urandom_range(0, 3));
            new_match = (c % 23 == 0);
            tick();
        end
        player_valid = 1'b0; new_match = 1'b0;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rps_opponent.md
RPS_OPPONENT -- requirements
Module: rps_opponent

Interface
REQ-001 Parameter SEED, default 8'hA5, is the LFSR reset value; a value of 0 SHALL be replaced by 8'h01.
REQ-002 Parameter MATCH_LEN, default 3, is the number of round wins that ends a match; the legal range SHALL be 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 player_valid  input  1  player move present on player.
REQ-006 player  input  2  player move: 00=Rock, 01=Paper, 10=Scissors, 11=invalid.
REQ-007 new_match  input  1  request to clear scores and start a new match.
REQ-008 player_ready  output  1  block can accept a move.
REQ-009 computer  output  2  computer move for the current round, same encoding as player, never 11.
REQ-010 result_valid  output  1  result and scores are updated; a one-cycle pulse.
REQ-011 result  output  2  round outcome: 00=draw, 01=player wins, 10=computer wins, 11=invalid player move.
REQ-012 player_score  output  4  player round wins in the current match.
REQ-013 computer_score  output  4  computer round wins in the current match.
REQ-014 match_over  output  1  one score has reached MATCH_LEN.

Function
REQ-015 The 8-bit Fibonacci LFSR SHALL advance on every clock edge in every state: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-016 The move is selected from the pre-advance LFSR value as follows:
- lfsr[1:0] when it is not 11;
- otherwise lfsr[3:2] when that is not 11;
- otherwise 00.
REQ-017 The FSM SHALL have four states: IDLE, JUDGE, RESULT and OVER; player_ready SHALL be 1 only in IDLE.
REQ-018 Accept occurs on an edge in IDLE with player_valid=1: the block SHALL register player, load computer with the selected move, and move to JUDGE.
REQ-019 In JUDGE, on the next edge, the block SHALL:
- register result;
- increment the winner's score;
- set result_valid=1;
- move to RESULT.
REQ-020 Win rules SHALL be: Rock beats Scissors, Paper beats Rock, Scissors beats Paper; equal moves are a draw; a player move of 11 gives result 11 and no score change.
REQ-021 In RESULT, on the next edge, result_valid SHALL clear, and the FSM SHALL go to OVER if either score equals MATCH_LEN, otherwise to IDLE.
REQ-022 Latency SHALL be: result_valid is high for exactly the cycle between edges k+1 and k+2 after an accept at edge k; the next accept can occur no earlier than edge k+3.
REQ-023 computer and result SHALL hold their values until the next accept or until new_match.
REQ-024 In OVER, match_over SHALL be 1 and player_valid SHALL be ignored.
REQ-025 A new_match in OVER SHALL, on the next edge, clear both scores, match_over and result, and return the FSM to IDLE.
REQ-026 A new_match in IDLE SHALL clear both scores on that edge; if an accept happens on the same edge, the move SHALL still be taken and SHALL count toward the new match.
REQ-027 new_match SHALL be ignored in JUDGE and RESULT.
REQ-028 A score SHALL never exceed MATCH_LEN.

Reset
REQ-029 While rst_n=0, the block SHALL hold:
- state=IDLE, lfsr=SEED;
- computer=00, result=00;
- result_valid=0, player_score=0, computer_score=0, match_over=0;
- player_ready=1.
REQ-030 Reset asserted mid-round (in JUDGE or RESULT) SHALL discard the round, with no result_valid pulse after release.

Verification
REQ-031 Reset release, then player=00 with player_valid=1 on the first edge -> computer=01, then result=10 with result_valid=1 for one cycle, computer_score=1, player_score=0.
REQ-032 Same timing with player=01 -> computer=01, result=00, both scores unchanged at 0.
REQ-033 player=11 accepted -> result=11, scores unchanged, FSM returns to IDLE.
REQ-034 MATCH_LEN=1 with the REQ-031 stimulus -> match_over=1 and player_ready=0, player_valid is ignored for 10 cycles; new_match pulse -> scores=0 and player_ready=1 on the next cycle.
REQ-035 player_valid held at 1 continuously -> accepts exactly every 3 cycles; result_valid never high for two consecutive cycles; the LFSR sequence matches the reference polynomial over 300 cycles.
REQ-036 rst_n pulled low in JUDGE -> all outputs take their reset values immediately, and no result_valid occurs after release.
